mmc3_scanline_irq: RTL

- Scanline IRQ unit for the MMC3-family mappers in the mapper layer.
- Consumes the PPU address bus as the top level presents it (ppu_addr_in[12]) and produces the cartridge irq line that the top level drives out.
- Also consumes already-decoded CPU register writes from the mapper register decoder and implements the $C000/$C001/$E000/$E001 register pair semantics.
- Runs entirely in the m2 clock domain. PPU A12 is synchronised and low-time filtered before it is used.

---
 rtl/mmc3_pkg.sv | 24 ++
 rtl/a12_edge_filter.sv | 49 ++++
 rtl/mmc3_scanline_irq.sv | 111 +++++++++++
 3 files changed

// File: rtl/mmc3_pkg.sv
// Shared constants and payload types for the MMC3 scanline IRQ unit.
package mmc3_pkg;

  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned LOW_W       = 3;
  localparam int unsigned LOW_MIN_DEF = 3;

  localparam logic [ADDR_W-1:0] REG_LATCH   = 3'b100;
  localparam logic [ADDR_W-1:0] REG_RELOAD  = 3'b101;
  localparam logic [ADDR_W-1:0] REG_DISABLE = 3'b110;
  localparam logic [ADDR_W-1:0] REG_ENABLE  = 3'b111;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cpu_wr_t;

  function automatic logic wr_hit(input cpu_wr_t wr, input logic [ADDR_W-1:0] sel);
    return wr.en && (wr.addr == sel);
  endfunction

endpackage

// File: rtl/a12_edge_filter.sv
// Synchronises PPU A12 into the m2 domain and emits one clock event per
// rising edge that follows a sufficiently long low period.
module a12_edge_filter
  import mmc3_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOW_MIN     = LOW_MIN_DEF
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic a12_i,
  output logic clk_ev_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   a12_s;
  logic                   a12_d_q;
  logic [LOW_W-1:0]       low_cnt_q;
  logic [LOW_W-1:0]       low_cnt_d;

  assign a12_s = sync_q[SYNC_STAGES-1];

  // Low-time counter saturates so long low periods never wrap.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], a12_i};
    low_cnt_d = low_cnt_q;
    if (a12_s) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_W'(LOW_MIN)) begin
      low_cnt_d = low_cnt_q + LOW_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sync_q    <= '0;
      a12_d_q   <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      a12_d_q   <= a12_s;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign clk_ev_c_o = a12_s && !a12_d_q && (low_cnt_q == LOW_W'(LOW_MIN));

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline counter and IRQ: filtered A12 edges decrement/reload an
// 8-bit counter, and reaching zero latches a sticky active-low IRQ.
module mmc3_scanline_irq
  import mmc3_pkg::*;
#(
  parameter int unsigned LOW_MIN     = LOW_MIN_DEF,
  parameter bit          REV_A       = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              m2,
  input  logic              reset,
  input  logic              ppu_a12,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              irq,
  output logic [DATA_W-1:0] counter_dbg
);

  logic              clr;
  logic              clk_ev_c;
  cpu_wr_t           wr;

  logic [DATA_W-1:0] latch_q,   latch_d;
  logic [DATA_W-1:0] counter_q, counter_d;
  logic              reload_q,  reload_d;
  logic              irq_en_q,  irq_en_d;
  logic              pending_q, pending_d;
  logic              irq_q,     irq_d;

  logic [DATA_W-1:0] next_cnt;
  logic              step_irq_en;
  logic              arm_ok;

  assign clr = reset || !enable;
  assign wr  = '{en: wr_en, addr: wr_addr, data: wr_data};

  a12_edge_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOW_MIN     (LOW_MIN)
  ) u_filter (
    .clk_i      (m2),
    .clr_i      (clr),
    .a12_i      (ppu_a12),
    .clk_ev_c_o (clk_ev_c)
  );

  // Step first, then let register writes override the fields they touch.
  always_comb begin
    latch_d     = latch_q;
    counter_d   = counter_q;
    reload_d    = reload_q;
    irq_en_d    = irq_en_q;
    pending_d   = pending_q;
    irq_d       = ~pending_q;
    next_cnt    = counter_q;
    step_irq_en = irq_en_q || wr_hit(wr, REG_ENABLE);
    arm_ok      = REV_A ? ((counter_q != '0) || reload_q) : 1'b1;

    if (clk_ev_c) begin
      if ((counter_q == '0) || reload_q) begin
        next_cnt = latch_q;
        reload_d = 1'b0;
      end else begin
        next_cnt = counter_q - DATA_W'(1);
      end
      counter_d = next_cnt;
      if ((next_cnt == '0) && step_irq_en && arm_ok) begin
        pending_d = 1'b1;
      end
    end

    if (wr_hit(wr, REG_LATCH)) begin
      latch_d = wr.data;
    end
    if (wr_hit(wr, REG_RELOAD)) begin
      counter_d = '0;
      reload_d  = 1'b1;
    end
    if (wr_hit(wr, REG_DISABLE)) begin
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
    end
    if (wr_hit(wr, REG_ENABLE)) begin
      irq_en_d = 1'b1;
    end
  end

  always_ff @(posedge m2) begin
    if (clr) begin
      latch_q   <= '0;
      counter_q <= '0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b1;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq         = irq_q;
  assign counter_dbg = counter_q;

endmodule
